// File: rtl/barrier_manager_if.sv
// Bundles the per-frame control, spawn parameters, player/pixel coordinates and
// status outputs of barrier_manager.
interface barrier_manager_if;
    logic       Frame_Tick;
    logic       Game_Start;
    logic       Spawn_Req;
    logic [9:0] Random_BarrierX;
    logic [9:0] Random_BarrierY;
    logic [9:0] Random_Barrier_Height;
    logic [9:0] Random_Barrier_Length;
    logic [9:0] Player_X;
    logic [9:0] Player_Y;
    logic [9:0] Player_Size;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       Barrier_On;
    logic [3:0] Active_Mask;
    logic       Spawn_Ack;
    logic       Spawn_Drop;
    logic       Collision;

    modport master (
        output Frame_Tick, Game_Start, Spawn_Req,
        output Random_BarrierX, Random_BarrierY, Random_Barrier_Height, Random_Barrier_Length,
        output Player_X, Player_Y, Player_Size, DrawX, DrawY,
        input  Barrier_On, Active_Mask, Spawn_Ack, Spawn_Drop, Collision
    );

    modport slave (
        input  Frame_Tick, Game_Start, Spawn_Req,
        input  Random_BarrierX, Random_BarrierY, Random_Barrier_Height, Random_Barrier_Length,
        input  Player_X, Player_Y, Player_Size, DrawX, DrawY,
        output Barrier_On, Active_Mask, Spawn_Ack, Spawn_Drop, Collision
    );
endinterface

// File: rtl/barrier_manager.sv
// Four-slot scrolling barrier store: spawns, scrolls and retires barriers, detects
// player collisions per frame and produces a registered per-pixel barrier flag.
module barrier_manager #(
    parameter int unsigned SCROLL_STEP = 2,
    parameter int unsigned NUM_SLOTS   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    barrier_manager_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_SLOTS);
    localparam logic [10:0] Step = 11'(SCROLL_STEP);

    typedef enum logic [1:0] {StIdle, StRun, StHit} state_e;

    state_e               state_q;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [9:0]           h_q [NUM_SLOTS];
    logic [9:0]           l_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] active_q;
    logic                 barrier_on_q, spawn_ack_q, spawn_drop_q, collision_q;

    logic [10:0]          right_e [NUM_SLOTS];
    logic [10:0]          bottom_e [NUM_SLOTS];
    logic [9:0]           x_scr [NUM_SLOTS];
    logic [9:0]           l_scr [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] overlap, pix_in, retire;
    logic [10:0]          player_r, player_b;
    logic                 hit, have_free;
    logic [IdxW-1:0]      free_idx;

    // All edges are 11 bits wide so barriers near the right border never wrap.
    always_comb begin
        player_r  = {1'b0, bus.Player_X} + {1'b0, bus.Player_Size};
        player_b  = {1'b0, bus.Player_Y} + {1'b0, bus.Player_Size};
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            right_e[i]  = {1'b0, x_q[i]} + {1'b0, l_q[i]};
            bottom_e[i] = {1'b0, y_q[i]} + {1'b0, h_q[i]};
            overlap[i]  = active_q[i]
                        && ({1'b0, bus.Player_X} < right_e[i]) && ({1'b0, x_q[i]} < player_r)
                        && ({1'b0, bus.Player_Y} < bottom_e[i]) && ({1'b0, y_q[i]} < player_b);
            pix_in[i]   = active_q[i]
                        && (x_q[i] <= bus.DrawX) && ({1'b0, bus.DrawX} < right_e[i])
                        && (y_q[i] <= bus.DrawY) && ({1'b0, bus.DrawY} < bottom_e[i]);
            retire[i]   = ({1'b0, x_q[i]} < Step) && (right_e[i] <= Step);
            if ({1'b0, x_q[i]} < Step) begin
                x_scr[i] = '0;
                l_scr[i] = l_q[i] - 10'(Step - {1'b0, x_q[i]});
            end else begin
                x_scr[i] = x_q[i] - 10'(Step);
                l_scr[i] = l_q[i];
            end
        end
        // Scan downward so the lowest free index wins; retiring slots are still active here.
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                have_free = 1'b1;
                free_idx  = IdxW'(i);
            end
        end
        hit = |overlap;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            active_q     <= '0;
            barrier_on_q <= 1'b0;
            spawn_ack_q  <= 1'b0;
            spawn_drop_q <= 1'b0;
            collision_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                h_q[i] <= '0;
                l_q[i] <= '0;
            end
        end else begin
            barrier_on_q <= |pix_in;
            spawn_ack_q  <= 1'b0;
            spawn_drop_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.Game_Start) begin
                        state_q  <= StRun;
                        active_q <= '0;
                    end
                end
                StRun: begin
                    if (bus.Game_Start) begin
                        active_q <= '0;
                    end else begin
                        // A collision freezes the slots with their pre-scroll positions.
                        if (bus.Frame_Tick && hit) begin
                            state_q     <= StHit;
                            collision_q <= 1'b1;
                        end else if (bus.Frame_Tick) begin
                            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                                if (active_q[i]) begin
                                    if (retire[i]) begin
                                        active_q[i] <= 1'b0;
                                    end else begin
                                        x_q[i] <= x_scr[i];
                                        l_q[i] <= l_scr[i];
                                    end
                                end
                            end
                        end
                        if (bus.Spawn_Req) begin
                            if (have_free) begin
                                x_q[free_idx]      <= bus.Random_BarrierX;
                                y_q[free_idx]      <= bus.Random_BarrierY;
                                h_q[free_idx]      <= bus.Random_Barrier_Height;
                                l_q[free_idx]      <= bus.Random_Barrier_Length;
                                active_q[free_idx] <= 1'b1;
                                spawn_ack_q        <= 1'b1;
                            end else begin
                                spawn_drop_q <= 1'b1;
                            end
                        end
                    end
                end
                StHit: begin
                    if (bus.Game_Start) begin
                        state_q     <= StRun;
                        collision_q <= 1'b0;
                        active_q    <= '0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    collision_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Barrier_On  = barrier_on_q;
    assign bus.Active_Mask = active_q;
    assign bus.Spawn_Ack   = spawn_ack_q;
    assign bus.Spawn_Drop  = spawn_drop_q;
    assign bus.Collision   = collision_q;

endmodule

// File: tb/tb_barrier_manager.sv
// Directed bench for barrier_manager: stimulus queues expectations, a negedge
// monitor pops and compares them against level probes and spawn-outcome pulses.
module tb_barrier_manager;

    localparam int ExpNone = 0;
    localparam int ExpAck  = 1;
    localparam int ExpDrop = 2;

    logic Clk = 1'b0;
    logic Reset;

    barrier_manager_if bus ();

    barrier_manager #(
        .SCROLL_STEP(2),
        .NUM_SLOTS  (4)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic       on;
        logic       coll;
    } lvl_t;

    typedef struct {
        string name;
        bit    drop;
    } ev_t;

    lvl_t lvl_q[$];
    ev_t  ev_q[$];
    lvl_t e_lvl;
    ev_t  e_ev;
    int   checks = 0;
    int   errors = 0;
    logic probe  = 1'b0;
    logic drain  = 1'b0;

    always @(negedge Clk) begin
        if (probe) begin
            checks++;
            if (lvl_q.size() == 0) begin
                errors++;
                $display("FAIL probe_queue: probe with no expectation queued");
            end else begin
                e_lvl = lvl_q.pop_front();
                if (bus.Active_Mask !== e_lvl.mask || bus.Barrier_On !== e_lvl.on ||
                    bus.Collision !== e_lvl.coll) begin
                    errors++;
                    $display("FAIL %s: got mask=%b on=%b coll=%b, expected mask=%b on=%b coll=%b",
                             e_lvl.name, bus.Active_Mask, bus.Barrier_On, bus.Collision,
                             e_lvl.mask, e_lvl.on, e_lvl.coll);
                end
            end
        end
        if (bus.Spawn_Ack === 1'b1 || bus.Spawn_Drop === 1'b1) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got ack=%b drop=%b, expected no pulse",
                         bus.Spawn_Ack, bus.Spawn_Drop);
            end else begin
                e_ev = ev_q.pop_front();
                if (bus.Spawn_Ack !== !e_ev.drop || bus.Spawn_Drop !== e_ev.drop) begin
                    errors++;
                    $display("FAIL %s: got ack=%b drop=%b, expected ack=%b drop=%b", e_ev.name,
                             bus.Spawn_Ack, bus.Spawn_Drop, !e_ev.drop, e_ev.drop);
                end
            end
        end
        if (drain) begin
            checks++;
            if (ev_q.size() != 0 || lvl_q.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d pulses and %0d probes outstanding, expected 0 and 0",
                         ev_q.size(), lvl_q.size());
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string n, input logic [3:0] m, input logic on, input logic c);
        lvl_t l;
        l.name = n;
        l.mask = m;
        l.on   = on;
        l.coll = c;
        lvl_q.push_back(l);
        probe = 1'b1;
        @(negedge Clk);
        #1;
        probe = 1'b0;
        step();
    endtask

    task automatic expect_ev(input string n, input int kind);
        ev_t v;
        if (kind != ExpNone) begin
            v.name = n;
            v.drop = (kind == ExpDrop);
            ev_q.push_back(v);
        end
    endtask

    task automatic set_rand(input int x, input int y, input int h, input int l);
        bus.Random_BarrierX       = 10'(x);
        bus.Random_BarrierY       = 10'(y);
        bus.Random_Barrier_Height = 10'(h);
        bus.Random_Barrier_Length = 10'(l);
    endtask

    task automatic spawn(input string n, input int x, input int y, input int h, input int l,
                         input int kind, input bit with_tick);
        set_rand(x, y, h, l);
        expect_ev(n, kind);
        bus.Spawn_Req  = 1'b1;
        bus.Frame_Tick = with_tick;
        step();
        bus.Spawn_Req  = 1'b0;
        bus.Frame_Tick = 1'b0;
    endtask

    task automatic frame();
        bus.Frame_Tick = 1'b1;
        step();
        bus.Frame_Tick = 1'b0;
    endtask

    task automatic start();
        bus.DrawX      = 10'd1023;
        bus.DrawY      = 10'd1023;
        bus.Game_Start = 1'b1;
        step();
        bus.Game_Start = 1'b0;
    endtask

    task automatic set_player(input int x, input int y, input int s);
        bus.Player_X    = 10'(x);
        bus.Player_Y    = 10'(y);
        bus.Player_Size = 10'(s);
    endtask

    task automatic pix(input string n, input int dx, input int dy, input logic [3:0] m,
                       input logic on, input logic c);
        bus.DrawX = 10'(dx);
        bus.DrawY = 10'(dy);
        step();
        check(n, m, on, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset          = 1'b1;
        bus.Frame_Tick = 1'b0;
        bus.Game_Start = 1'b0;
        bus.Spawn_Req  = 1'b0;
        bus.DrawX      = 10'd1023;
        bus.DrawY      = 10'd1023;
        set_rand(0, 0, 0, 0);
        set_player(900, 900, 10);
        step();
        step();
        check("reset_state", 4'b0000, 1'b0, 1'b0);
        Reset = 1'b0;

        spawn("idle_spawn", 200, 45, 20, 30, ExpNone, 1'b0);
        check("idle_spawn_ignored", 4'b0000, 1'b0, 1'b0);
        frame();
        start();
        check("start", 4'b0000, 1'b0, 1'b0);

        // First barrier and its pixel boundaries
        spawn("ack_slot0", 200, 45, 20, 30, ExpAck, 1'b0);
        check("spawn0_mask", 4'b0001, 1'b0, 1'b0);
        pix("pix_inside", 210, 50, 4'b0001, 1'b1, 1'b0);
        pix("pix_right_edge", 230, 50, 4'b0001, 1'b0, 1'b0);
        pix("pix_corner_in", 229, 64, 4'b0001, 1'b1, 1'b0);
        pix("pix_bottom_edge", 200, 65, 4'b0001, 1'b0, 1'b0);
        pix("pix_left_out", 199, 50, 4'b0001, 1'b0, 1'b0);

        // Fill all slots, then overflow
        spawn("ack_slot1", 300, 100, 10, 10, ExpAck, 1'b0);
        spawn("ack_slot2", 400, 100, 10, 10, ExpAck, 1'b0);
        spawn("ack_slot3", 500, 100, 10, 10, ExpAck, 1'b0);
        check("mask_full", 4'b1111, 1'b0, 1'b0);
        spawn("drop_fifth", 600, 300, 10, 10, ExpDrop, 1'b0);
        check("drop_mask", 4'b1111, 1'b0, 1'b0);
        pix("drop_not_loaded", 605, 305, 4'b1111, 1'b0, 1'b0);
        pix("slot3_loaded", 505, 105, 4'b1111, 1'b1, 1'b0);
        start();
        check("restart_clears", 4'b0000, 1'b0, 1'b0);

        // Partial scroll past the left edge, then retirement
        spawn("ack_x1", 1, 10, 5, 2, ExpAck, 1'b0);
        pix("edge_x1", 2, 10, 4'b0001, 1'b1, 1'b0);
        pix("edge_x1_left", 0, 10, 4'b0001, 1'b0, 1'b0);
        frame();
        pix("partial_x0", 0, 10, 4'b0001, 1'b1, 1'b0);
        pix("partial_l1", 1, 10, 4'b0001, 1'b0, 1'b0);
        frame();
        check("retire", 4'b0000, 1'b0, 1'b0);
        spawn("ack_x1_l5", 1, 10, 5, 5, ExpAck, 1'b0);
        frame();
        pix("trim_l4_in", 3, 10, 4'b0001, 1'b1, 1'b0);
        pix("trim_l4_out", 4, 10, 4'b0001, 1'b0, 1'b0);

        // A slot retiring on the spawn edge is not free
        start();
        spawn("ack_r0", 1, 200, 5, 1, ExpAck, 1'b0);
        spawn("ack_r1", 500, 200, 5, 5, ExpAck, 1'b0);
        spawn("ack_r2", 510, 200, 5, 5, ExpAck, 1'b0);
        spawn("ack_r3", 520, 200, 5, 5, ExpAck, 1'b0);
        spawn("drop_retiring", 700, 200, 5, 5, ExpDrop, 1'b1);
        check("retire_not_free", 4'b1110, 1'b0, 1'b0);
        spawn("ack_reuse0", 700, 200, 5, 5, ExpAck, 1'b0);
        check("reuse_slot0", 4'b1111, 1'b0, 1'b0);

        // Spawn and tick on the same edge
        start();
        spawn("ack_s100", 100, 10, 5, 10, ExpAck, 1'b0);
        spawn("ack_same_edge", 300, 10, 5, 10, ExpAck, 1'b1);
        check("same_edge_mask", 4'b0011, 1'b0, 1'b0);
        pix("s0_x98", 98, 10, 4'b0011, 1'b1, 1'b0);
        pix("s0_left", 97, 10, 4'b0011, 1'b0, 1'b0);
        pix("s0_right_in", 107, 10, 4'b0011, 1'b1, 1'b0);
        pix("s0_right_out", 108, 10, 4'b0011, 1'b0, 1'b0);
        pix("s1_unscrolled", 300, 10, 4'b0011, 1'b1, 1'b0);
        pix("s1_left", 299, 10, 4'b0011, 1'b0, 1'b0);

        // Right edge beyond 1023 must not wrap
        start();
        spawn("ack_far", 1000, 500, 5, 30, ExpAck, 1'b0);
        pix("nowrap_right", 1020, 500, 4'b0001, 1'b1, 1'b0);
        pix("nowrap_low", 5, 500, 4'b0001, 1'b0, 1'b0);

        // Collision: touching edge is safe, overlap freezes the round
        start();
        spawn("ack_hit", 200, 45, 20, 30, ExpAck, 1'b0);
        set_player(230, 50, 16);
        frame();
        check("no_hit_touch", 4'b0001, 1'b0, 1'b0);
        pix("scrolled_198", 198, 45, 4'b0001, 1'b1, 1'b0);
        set_player(190, 50, 16);
        frame();
        check("hit", 4'b0001, 1'b1, 1'b1);
        pix("hit_no_scroll", 197, 45, 4'b0001, 1'b0, 1'b1);
        pix("hit_drawn", 198, 45, 4'b0001, 1'b1, 1'b1);
        spawn("hit_spawn", 300, 10, 5, 5, ExpNone, 1'b0);
        check("hit_spawn_ignored", 4'b0001, 1'b1, 1'b1);
        frame();
        pix("hit_frame_frozen", 197, 45, 4'b0001, 1'b0, 1'b1);
        start();
        check("hit_restart", 4'b0000, 1'b0, 1'b0);
        set_player(900, 900, 10);

        // Asynchronous reset in the middle of a round
        spawn("ack_pre_reset", 200, 45, 20, 30, ExpAck, 1'b0);
        pix("pre_reset", 210, 50, 4'b0001, 1'b1, 1'b0);
        set_rand(300, 50, 10, 10);
        bus.Spawn_Req = 1'b1;
        @(posedge Clk);
        #2;
        Reset         = 1'b1;
        bus.Spawn_Req = 1'b0;
        check("async_reset", 4'b0000, 1'b0, 1'b0);
        Reset = 1'b0;
        spawn("post_reset", 200, 45, 20, 30, ExpNone, 1'b0);
        check("post_reset_ignored", 4'b0000, 1'b0, 1'b0);
        start();
        spawn("ack_post_start", 200, 45, 20, 30, ExpAck, 1'b0);
        check("post_reset_run", 4'b0001, 1'b0, 1'b0);

        drain = 1'b1;
        @(negedge Clk);
        #1;
        drain = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
